// File: rtl/mips_alu_pkg.sv
// Shared definitions for the bit-serial MIPS ALU: operation codes, sequencer
// states and small decode helpers.
package mips_alu_pkg;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_XOR = 3'b100,
    ALU_NOR = 3'b101,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } alu_state_t;

  // Only ADD and SUB report signed overflow.
  function automatic logic is_arith(input alu_ctrl_t op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

  // SUB and SLT run the adder as a - b (inverted b, carry-in 1).
  function automatic logic uses_sub(input alu_ctrl_t op);
    return (op == ALU_SUB) || (op == ALU_SLT);
  endfunction

endpackage

// File: rtl/mips_alu_1_logic.sv
// One-bit ALU slice: selects the per-bit logic result, the adder sum bit or
// the SLT "less" input according to the operation code.
module mips_alu_1_logic
  import mips_alu_pkg::*;
(
  input  logic      a,
  input  logic      b,
  input  logic      s_temp,
  input  logic      less,
  input  alu_ctrl_t ctrl,
  output logic      y
);

  // Per-bit operation select; unsupported codes yield 0.
  always_comb begin
    y = 1'b0;
    case (ctrl)
      ALU_AND:          y = a & b;
      ALU_OR:           y = a | b;
      ALU_XOR:          y = a ^ b;
      ALU_NOR:          y = ~(a | b);
      ALU_ADD, ALU_SUB: y = s_temp;
      ALU_SLT:          y = less;
      default:          y = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_alu_serial_seq.sv
// Bit-serial MIPS ALU: operands are latched on start, one bit per cycle is
// pushed through a single 1-bit slice LSB first, and the result is presented
// with a one-cycle done pulse.
module mips_alu_serial_seq
  import mips_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       ctrl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  alu_state_t       state_r;
  alu_ctrl_t        ctrl_r;
  logic [WIDTH-1:0] a_sh_r;
  logic [WIDTH-1:0] b_sh_r;
  logic [WIDTH-2:0] res_sh_r;
  logic [CNT_W-1:0] cnt_r;
  logic             carry_r;
  logic             busy_r;
  logic             done_r;
  logic             zero_r;
  logic             ovf_r;
  logic [WIDTH-1:0] result_r;

  logic             b_eff_s;
  logic             sum_s;
  logic             cout_s;
  logic             ovf_raw_s;
  logic             slice_y_s;
  logic [WIDTH-1:0] shifted_s;
  logic [WIDTH-1:0] final_res_s;
  logic             final_ovf_s;

  // Serial full adder on the current operand bits.
  always_comb begin
    b_eff_s   = b_sh_r[0] ^ uses_sub(ctrl_r);
    sum_s     = a_sh_r[0] ^ b_eff_s ^ carry_r;
    cout_s    = (a_sh_r[0] & b_eff_s) | (a_sh_r[0] & carry_r) | (b_eff_s & carry_r);
    ovf_raw_s = carry_r ^ cout_s;
  end

  mips_alu_1_logic u_slice (
    .a      (a_sh_r[0]),
    .b      (b_sh_r[0]),
    .s_temp (sum_s),
    .less   (1'b0),
    .ctrl   (ctrl_r),
    .y      (slice_y_s)
  );

  // Result as it will look after the MSB is shifted in, with the SLT fix-up.
  always_comb begin
    shifted_s = {slice_y_s, res_sh_r};
    if (ctrl_r == ALU_SLT) begin
      final_res_s = {{(WIDTH-1){1'b0}}, sum_s ^ ovf_raw_s};
    end else begin
      final_res_s = shifted_s;
    end
    if (is_arith(ctrl_r)) begin
      final_ovf_s = ovf_raw_s;
    end else begin
      final_ovf_s = 1'b0;
    end
  end

  // Sequencer, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      ctrl_r   <= ALU_AND;
      a_sh_r   <= {WIDTH{1'b0}};
      b_sh_r   <= {WIDTH{1'b0}};
      res_sh_r <= {(WIDTH-1){1'b0}};
      cnt_r    <= {CNT_W{1'b0}};
      carry_r  <= 1'b0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      zero_r   <= 1'b0;
      ovf_r    <= 1'b0;
      result_r <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            state_r  <= ST_RUN;
            busy_r   <= 1'b1;
            a_sh_r   <= a;
            b_sh_r   <= b;
            ctrl_r   <= alu_ctrl_t'(ctrl);
            carry_r  <= uses_sub(alu_ctrl_t'(ctrl));
            cnt_r    <= {CNT_W{1'b0}};
            res_sh_r <= {(WIDTH-1){1'b0}};
          end
        end
        ST_RUN: begin
          a_sh_r   <= {1'b0, a_sh_r[WIDTH-1:1]};
          b_sh_r   <= {1'b0, b_sh_r[WIDTH-1:1]};
          res_sh_r <= shifted_s[WIDTH-1:1];
          carry_r  <= cout_s;
          if (cnt_r == LAST_BIT) begin
            state_r  <= ST_DONE;
            done_r   <= 1'b1;
            result_r <= final_res_s;
            zero_r   <= (final_res_s == {WIDTH{1'b0}});
            ovf_r    <= final_ovf_s;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
          carry_r <= 1'b0;
          cnt_r   <= {CNT_W{1'b0}};
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign result   = result_r;
  assign zero     = zero_r;
  assign overflow = ovf_r;

endmodule

// File: tb/tb_mips_alu_serial_seq.sv
// Directed scoreboard bench for the bit-serial ALU at WIDTH=32: expected
// values come from a behavioural model and are checked when done pulses.
module tb_mips_alu_serial_seq;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         start;
  logic [2:0]   ctrl;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] result;
  logic         zero;
  logic         overflow;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [W-1:0] res;
    logic         zero;
    logic         ovf;
  } exp_t;

  exp_t sb[$];

  mips_alu_serial_seq #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .ctrl     (ctrl),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .zero     (zero),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [2:0] c, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    logic [W-1:0] r;
    logic v;
    v = 1'b0;
    case (c)
      3'b000: r = x & y;
      3'b001: r = x | y;
      3'b100: r = x ^ y;
      3'b101: r = ~(x | y);
      3'b010: begin r = x + y; v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]); end
      3'b110: begin r = x - y; v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]); end
      3'b111: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
    e.res  = r;
    e.zero = (r == 32'd0);
    e.ovf  = v;
    return e;
  endfunction

  // Runs one operation; with disturb set, random inputs and start pulses are
  // applied while busy (including the DONE cycle) and must be ignored.
  task automatic run_op(input string tag, input logic [2:0] c, input logic [W-1:0] x,
                        input logic [W-1:0] y, input bit disturb);
    exp_t e;
    exp_t got;
    int edges;
    bit seen;
    @(negedge clk);
    ctrl  = c;
    a     = x;
    b     = y;
    start = 1'b1;
    sb.push_back(model(c, x, y));
    edges = 0;
    seen  = 1'b0;
    for (int k = 0; k < 100 && !seen; k++) begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (k == 0) check({tag, "_busy"}, {63'd0, busy}, 64'd1);
      if (done) begin
        seen = 1'b1;
        start = disturb;
      end else begin
        a     = $urandom;
        b     = $urandom;
        ctrl  = 3'($urandom_range(0, 7));
        start = disturb ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
    check({tag, "_done_seen"}, {63'd0, seen}, 64'd1);
    check({tag, "_latency"}, 64'(edges), 64'(W + 1));
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      got.res  = result;
      got.zero = zero;
      got.ovf  = overflow;
      check({tag, "_result"}, 64'(got.res), 64'(e.res));
      check({tag, "_zero"}, {63'd0, got.zero}, {63'd0, e.zero});
      check({tag, "_ovf"}, {63'd0, got.ovf}, {63'd0, e.ovf});
      @(negedge clk);
      start = 1'b0;
      check({tag, "_pulse"}, {62'd0, done, busy}, 64'd0);
      check({tag, "_hold"}, {31'd0, result, zero}, {31'd0, e.res, e.zero});
    end
  endtask

  initial begin
    bit saw_done;
    reset = 1'b1;
    start = 1'b0;
    ctrl  = 3'b000;
    a     = 32'd0;
    b     = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_state", {29'd0, busy, done, zero, overflow, result}, 64'd0);
    reset = 1'b0;

    run_op("add_ovf",  3'b010, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    run_op("add_wrap", 3'b010, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    run_op("sub_eq",   3'b110, 32'h0000_0005, 32'h0000_0005, 1'b0);
    run_op("sub_ovf",  3'b110, 32'h8000_0000, 32'h0000_0001, 1'b0);
    run_op("slt_neg",  3'b111, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0);
    run_op("slt_min",  3'b111, 32'h8000_0000, 32'h0000_0001, 1'b0);
    run_op("slt_ge",   3'b111, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
    run_op("and",      3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0);
    run_op("or",       3'b001, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0);
    run_op("xor",      3'b100, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0);
    run_op("nor",      3'b101, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0);
    run_op("unsup",    3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("add_dist", 3'b010, 32'h1234_5678, 32'h0FED_CBA9, 1'b1);

    // Abort an operation with reset during its 10th RUN cycle.
    @(negedge clk);
    ctrl  = 3'b010;
    a     = 32'h0000_0F00;
    b     = 32'h0000_00F0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("abort_state", {29'd0, busy, done, zero, overflow, result}, 64'd0);
    saw_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    check("abort_no_done", {63'd0, saw_done}, 64'd0);

    run_op("sub_after", 3'b110, 32'h0000_0003, 32'h0000_0007, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
